// File: rtl/icache_sa_refill_pkg.sv
// Shared definitions for the set-associative refill I-cache: default geometry,
// derived field widths, FSM encoding and address field extraction.
package icache_sa_refill_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int WAYS_DEF       = 4;
  localparam int SETS_DEF       = 16;
  localparam int LINE_WORDS_DEF = 4;

  localparam int OFF_W  = $clog2(DATA_W_DEF / 8);
  localparam int WORD_W = $clog2(LINE_WORDS_DEF);
  localparam int SET_W  = $clog2(SETS_DEF);
  localparam int TAG_W  = ADDR_W_DEF - OFF_W - WORD_W - SET_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_INV  = 2'd3
  } state_t;

  // Right-justified bit field of an address; width must stay below the address width.
  function automatic logic [ADDR_W_DEF-1:0] addr_field(input logic [ADDR_W_DEF-1:0] addr,
                                                      input int lsb, input int width);
    logic [ADDR_W_DEF-1:0] mask;
    mask = (ADDR_W_DEF'(1) << width) - ADDR_W_DEF'(1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag/valid/data arrays with two combinational lookup ports,
// one data/tag write port and a per-set valid clear.
module icache_way
  import icache_sa_refill_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int SET_BITS   = 4,
  parameter int WORD_BITS  = 2,
  parameter int TAG_BITS   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SET_BITS-1:0]  lk_set1,
  input  logic [WORD_BITS-1:0] lk_word1,
  input  logic [TAG_BITS-1:0]  lk_tag1,
  output logic                 lk_valid1,
  output logic                 lk_hit1,
  output logic [DATA_W-1:0]    lk_data1,
  input  logic [SET_BITS-1:0]  lk_set2,
  input  logic [WORD_BITS-1:0] lk_word2,
  input  logic [TAG_BITS-1:0]  lk_tag2,
  output logic                 lk_valid2,
  output logic                 lk_hit2,
  output logic [DATA_W-1:0]    lk_data2,
  input  logic                 wr_en,
  input  logic [SET_BITS-1:0]  wr_set,
  input  logic [WORD_BITS-1:0] wr_word,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 tag_we,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic                 clr_en,
  input  logic [SET_BITS-1:0]  clr_set
);

  logic [SETS-1:0]     valid_r;
  logic [TAG_BITS-1:0] tag_r  [SETS];
  logic [DATA_W-1:0]   data_r [SETS][LINE_WORDS];

  assign lk_valid1 = valid_r[lk_set1];
  assign lk_hit1   = valid_r[lk_set1] && (tag_r[lk_set1] == lk_tag1);
  assign lk_data1  = data_r[lk_set1][lk_word1];
  assign lk_valid2 = valid_r[lk_set2];
  assign lk_hit2   = valid_r[lk_set2] && (tag_r[lk_set2] == lk_tag2);
  assign lk_data2  = data_r[lk_set2][lk_word2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (clr_en) begin
      valid_r[clr_set] <= 1'b0;
    end else if (tag_we) begin
      valid_r[wr_set] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid bits alone gate their visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[wr_set][wr_word] <= wr_data;
    end
    if (tag_we) begin
      tag_r[wr_set] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache_sa_refill.sv
// Dual-port N-way set-associative I-cache with round-robin replacement,
// burst line refill FSM and a one-set-per-cycle invalidate walk.
module icache_sa_refill
  import icache_sa_refill_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int WAYS       = WAYS_DEF,
  parameter int SETS       = SETS_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req1,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic              rd_req2,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_hit1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_hit2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              inv_req,
  output logic              inv_busy
);

  localparam int L_OFF_W  = $clog2(DATA_W / 8);
  localparam int L_WORD_W = $clog2(LINE_WORDS);
  localparam int L_SET_W  = $clog2(SETS);
  localparam int L_TAG_W  = ADDR_W - L_OFF_W - L_WORD_W - L_SET_W;
  localparam int WAY_W    = $clog2(WAYS);
  localparam int SET_LSB  = L_OFF_W + L_WORD_W;
  localparam int TAG_LSB  = SET_LSB + L_SET_W;
  localparam logic [L_WORD_W-1:0] LAST_BEAT = L_WORD_W'(LINE_WORDS - 1);
  localparam logic [L_SET_W-1:0]  LAST_SET  = L_SET_W'(SETS - 1);
  localparam logic [ADDR_W-1:0]   LINE_MASK = ~((ADDR_W'(1) << SET_LSB) - ADDR_W'(1));

  state_t               state_r;
  logic                 busy_r, inv_busy_r, mem_req_r, inv_pend_r;
  logic [ADDR_W-1:0]    mem_addr_r;
  logic [L_SET_W-1:0]   fill_set_r, inv_set_r;
  logic [L_TAG_W-1:0]   fill_tag_r;
  logic [WAY_W-1:0]     victim_r;
  logic [L_WORD_W-1:0]  beat_r;
  logic [WAY_W-1:0]     rr_r [SETS];

  logic [L_SET_W-1:0]   set1_s, set2_s, miss_set_s, clr_set_s;
  logic [L_WORD_W-1:0]  word1_s, word2_s;
  logic [L_TAG_W-1:0]   tag1_s, tag2_s;
  logic [WAYS-1:0]      way_hit1_s, way_hit2_s, way_valid1_s, way_valid2_s;
  logic [DATA_W-1:0]    way_data1_s [WAYS];
  logic [DATA_W-1:0]    way_data2_s [WAYS];
  logic [WAYS-1:0]      wr_en_s, tag_we_s, clr_en_s, miss_valid_s;
  logic                 miss_start_s, inv_go_s;
  logic [ADDR_W-1:0]    miss_addr_s;
  logic [WAY_W-1:0]     victim_s;

  assign set1_s     = L_SET_W'(addr_field(rd_addr1, SET_LSB, L_SET_W));
  assign word1_s    = L_WORD_W'(addr_field(rd_addr1, L_OFF_W, L_WORD_W));
  assign tag1_s     = L_TAG_W'(addr_field(rd_addr1, TAG_LSB, L_TAG_W));
  assign set2_s     = L_SET_W'(addr_field(rd_addr2, SET_LSB, L_SET_W));
  assign word2_s    = L_WORD_W'(addr_field(rd_addr2, L_OFF_W, L_WORD_W));
  assign tag2_s     = L_TAG_W'(addr_field(rd_addr2, TAG_LSB, L_TAG_W));
  assign miss_set_s = L_SET_W'(addr_field(miss_addr_s, SET_LSB, L_SET_W));
  assign inv_go_s   = inv_req | inv_pend_r;

  assign busy     = busy_r;
  assign inv_busy = inv_busy_r;
  assign mem_req  = mem_req_r;
  assign mem_addr = mem_addr_r;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS),
      .SET_BITS(L_SET_W), .WORD_BITS(L_WORD_W), .TAG_BITS(L_TAG_W)
    ) u_way (
      .clk(clk), .rst(rst_n),
      .lk_set1(set1_s), .lk_word1(word1_s), .lk_tag1(tag1_s),
      .lk_valid1(way_valid1_s[g]), .lk_hit1(way_hit1_s[g]), .lk_data1(way_data1_s[g]),
      .lk_set2(set2_s), .lk_word2(word2_s), .lk_tag2(tag2_s),
      .lk_valid2(way_valid2_s[g]), .lk_hit2(way_hit2_s[g]), .lk_data2(way_data2_s[g]),
      .wr_en(wr_en_s[g]), .wr_set(fill_set_r), .wr_word(beat_r), .wr_data(mem_rdata),
      .tag_we(tag_we_s[g]), .wr_tag(fill_tag_r),
      .clr_en(clr_en_s[g]), .clr_set(clr_set_s)
    );
  end

  // Hits are blanked for the whole invalidate walk; data is zero on any miss.
  always_comb begin
    rd_hit1  = 1'b0;
    rd_data1 = '0;
    rd_hit2  = 1'b0;
    rd_data2 = '0;
    if (rd_req1 && (state_r != ST_INV) && (|way_hit1_s)) begin
      rd_hit1 = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if (way_hit1_s[w]) rd_data1 = rd_data1 | way_data1_s[w];
        else rd_data1 = rd_data1;
      end
    end else begin
      rd_hit1 = 1'b0;
    end
    if (rd_req2 && (state_r != ST_INV) && (|way_hit2_s)) begin
      rd_hit2 = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if (way_hit2_s[w]) rd_data2 = rd_data2 | way_data2_s[w];
        else rd_data2 = rd_data2;
      end
    end else begin
      rd_hit2 = 1'b0;
    end
  end

  always_comb begin
    miss_start_s = 1'b0;
    miss_addr_s  = '0;
    miss_valid_s = '0;
    if (rd_req1 && !rd_hit1) begin
      miss_start_s = 1'b1;
      miss_addr_s  = rd_addr1;
      miss_valid_s = way_valid1_s;
    end else if (rd_req2 && !rd_hit2) begin
      miss_start_s = 1'b1;
      miss_addr_s  = rd_addr2;
      miss_valid_s = way_valid2_s;
    end else begin
      miss_start_s = 1'b0;
    end
  end

  // Downward scan so the lowest-index invalid way wins over the rr pointer.
  always_comb begin
    victim_s = rr_r[miss_set_s];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!miss_valid_s[w]) victim_s = WAY_W'(w);
      else victim_s = victim_s;
    end
  end

  always_comb begin
    wr_en_s   = '0;
    tag_we_s  = '0;
    clr_en_s  = '0;
    clr_set_s = miss_set_s;
    case (state_r)
      ST_IDLE: begin
        if (!inv_go_s && miss_start_s) clr_en_s[victim_s] = 1'b1;
        else clr_en_s = '0;
      end
      ST_FILL: begin
        if (mem_rvalid) begin
          wr_en_s[victim_r] = 1'b1;
          if (beat_r == LAST_BEAT) tag_we_s[victim_r] = 1'b1;
          else tag_we_s = '0;
        end else begin
          wr_en_s = '0;
        end
      end
      ST_INV: begin
        clr_en_s  = '1;
        clr_set_s = inv_set_r;
      end
      default: begin
        clr_en_s = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      inv_busy_r <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= '0;
      inv_pend_r <= 1'b0;
      fill_set_r <= '0;
      fill_tag_r <= '0;
      victim_r   <= '0;
      beat_r     <= '0;
      inv_set_r  <= '0;
      for (int s = 0; s < SETS; s++) rr_r[s] <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (inv_go_s) begin
            state_r    <= ST_INV;
            inv_pend_r <= 1'b0;
            inv_set_r  <= '0;
            inv_busy_r <= 1'b1;
            busy_r     <= 1'b1;
          end else if (miss_start_s) begin
            state_r    <= ST_REQ;
            mem_req_r  <= 1'b1;
            mem_addr_r <= miss_addr_s & LINE_MASK;
            fill_set_r <= miss_set_s;
            fill_tag_r <= L_TAG_W'(addr_field(miss_addr_s, TAG_LSB, L_TAG_W));
            victim_r   <= victim_s;
            busy_r     <= 1'b1;
          end
        end
        ST_REQ: begin
          if (inv_req) inv_pend_r <= 1'b1;
          if (mem_ack) begin
            mem_req_r <= 1'b0;
            beat_r    <= '0;
            state_r   <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (inv_req) inv_pend_r <= 1'b1;
          if (mem_rvalid) begin
            beat_r <= beat_r + L_WORD_W'(1);
            if (beat_r == LAST_BEAT) begin
              if (victim_r == rr_r[fill_set_r]) begin
                rr_r[fill_set_r] <= rr_r[fill_set_r] + WAY_W'(1);
              end
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        ST_INV: begin
          rr_r[inv_set_r] <= '0;
          inv_set_r       <= inv_set_r + L_SET_W'(1);
          if (inv_set_r == LAST_SET) begin
            state_r    <= ST_IDLE;
            inv_busy_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/icache_sa_refill.md
Name: icache_sa_refill

Overview:
- Parametrised N-way set-associative instruction cache with two read ports for dual-issue fetch.
- Adds valid bits, per-set round-robin replacement, an internal line-refill FSM with a burst memory handshake, and a whole-cache invalidate walk.
- Sits between the fetch stage (two PCs per cycle) and the instruction bus/AXI bridge.

Parameters:
- ADDR_W, 32, address/PC width
- DATA_W, 32, instruction word width
- WAYS, 4, associativity (power of 2, >=2)
- SETS, 16, number of sets (power of 2)
- LINE_WORDS, 4, words per line (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-high reset (asserted = 1, matching the codebase RstEnable value)
- rd_req1  in  1  port-1 lookup valid
- rd_addr1  in  ADDR_W  port-1 PC
- rd_req2  in  1  port-2 lookup valid
- rd_addr2  in  ADDR_W  port-2 PC
- rd_hit1  out  1  port-1 hit
- rd_data1  out  DATA_W  port-1 instruction
- rd_hit2  out  1  port-2 hit
- rd_data2  out  DATA_W  port-2 instruction
- busy  out  1  FSM not IDLE
- mem_req  out  1  line read request
- mem_addr  out  ADDR_W  line-aligned request address
- mem_ack  in  1  request accepted
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  DATA_W  refill beat data
- inv_req  in  1  invalidate-all pulse
- inv_busy  out  1  invalidate in progress

Behaviour:
- Address split (LSB first):
  - byte offset: log2(DATA_W/8) bits
  - word: log2(LINE_WORDS) bits
  - set: log2(SETS) bits
  - tag: the remaining bits
- Lookup is combinational from registered arrays.
  - rd_hitN = rd_reqN & any way with valid & tag match & FSM not INV.
  - rd_dataN = the matching way's word; 0 on miss.
- Storage: tag, valid, data[WAYS][SETS][LINE_WORDS], plus a per-set round-robin pointer rr[SETS] (log2(WAYS) bits).
- Reset values:
  - all valid = 0, rr = 0, state IDLE, beat counter = 0
  - mem_req = 0, busy = 0, inv_busy = 0
  - rd_hit = 0 and rd_data = 0 (no valid lines)
  - Reset mid-operation aborts immediately: no line is left valid, and late mem_rvalid beats are ignored.
- States: IDLE, REQ, FILL, INV.
- IDLE:
  - If an invalidate is pending (inv_req now or latched), go to INV; invalidate takes priority over misses.
  - Else if rd_req1 & !rd_hit1, capture port-1 line address, go to REQ.
  - Else if rd_req2 & !rd_hit2, capture port-2 line address, go to REQ.
  - Port 1 has priority. A port-2 miss to a different line is not queued; it re-triggers when re-presented after return to IDLE.
- Victim selection, at IDLE->REQ:
  - Lowest-index invalid way in the set; otherwise way rr[set].
  - The victim's valid bit is cleared on that transition, so no stale hit can occur.
- REQ:
  - mem_req = 1 and mem_addr = captured line address (word bits zero), both held stable until mem_ack.
  - On mem_ack: mem_req drops the following cycle, beat counter = 0, go to FILL.
- FILL:
  - Each mem_rvalid writes mem_rdata into the victim at word[beat], then beat++.
  - On the beat where beat == LINE_WORDS-1: write tag, set valid, advance rr[set] by 1 (wraps at WAYS) only if the victim was way rr[set], go to IDLE.
  - Line becomes hittable the cycle after the last beat.
  - Beats arrive in ascending word order; gaps between beats are allowed.
- Hit-under-miss: hits to other lines are served in REQ and FILL. Lookups to the line being filled miss and do not re-trigger.
- inv_req arriving during REQ/FILL is latched (one pending flag) and serviced on return to IDLE.
- INV:
  - Clears the valid bits of one set per cycle, set 0..SETS-1, so it lasts SETS cycles.
  - Resets rr for each set.
  - inv_busy = 1 and all hits are forced to 0.
  - Then go to IDLE; a further inv_req during INV is absorbed.
- busy = (state != IDLE).

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, derived widths (OFF_W, WORD_W, SET_W, TAG_W), state encoding, and field-extract functions.
- One natural sub-module, icache_way: one way holding tag/valid/data arrays, with two combinational lookup ports and one write port. It is instantiated WAYS times with a generate loop; the top level holds the FSM, victim select and output muxing.

Test Plan:
- Cold miss: rd_req1 at 0x1C000004 -> rd_hit1=0, mem_req=1, mem_addr=0x1C000000. Ack, then beats 0x11,0x22,0x33,0x44 -> one cycle later a read of 0x1C000008 gives rd_hit1=1, rd_data1=0x33.
- Dual port: port1 hits 0x1C000000 while port2 misses 0x1C000010 -> rd_hit1=1 (data 0x11), mem_addr=0x1C000010. After fill, both ports hit in the same cycle.
- Replacement: fill 0x0, 0x100, 0x200, 0x300 (same set 0, ways 0-3), then miss 0x400 -> way 0 evicted. 0x0 misses, 0x100 still hits, rr[0]=1.
- Hit-under-miss: during FILL of 0x2000, read already-cached 0x0 -> rd_hit1=1. Reading 0x2000 -> rd_hit1=0, with no second mem_req.
- Invalidate during FILL: inv_req at beat 1 -> fill completes, then inv_busy=1 for exactly 16 cycles, then every prior address misses.
- Reset mid-fill: rst_n=1 after beat 2 -> mem_req=0, busy=0 immediately. Stray mem_rvalid ignored; 0x2000 misses after reset release.
